autoref_scheduler: RTL and testbench

Auto-refresh scheduler for the DRAM controller. It consumes the programmed refresh settings: enable, refresh interval, and tRFC. It generates refresh requests to the command arbiter, tracks postponed refreshes, and blocks the command path for tRFC after every issued refresh. It sits between the refresh configuration registers and the command arbiter/sequencer.

---
 rtl/autoref_scheduler_if.sv | 22 ++
 rtl/autoref_scheduler.sv | 124 ++++++++++++
 tb/tb_autoref_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/autoref_scheduler_if.sv
// Refresh handshake between the auto-refresh
// scheduler and the DRAM command arbiter.
interface autoref_scheduler_if;
  logic ref_req;
  logic ref_ack;
  logic ref_busy;
  logic ref_done;

  modport master (
    output ref_req,
    output ref_busy,
    output ref_done,
    input  ref_ack
  );

  modport slave (
    input  ref_req,
    input  ref_busy,
    input  ref_done,
    output ref_ack
  );
endinterface

// File: rtl/autoref_scheduler.sv
// Auto-refresh scheduler: interval ticks, postponed
// refresh tracking and tRFC blackout of the command path.
module autoref_scheduler #(
  parameter int CNT_W    = 28,
  parameter int MAX_PEND = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aref_en,
  input  logic [CNT_W-1:0] aref_interval,
  input  logic [CNT_W-1:0] trfc,
  autoref_scheduler_if.master arb,
  output logic [3:0]       pend_cnt,
  output logic             pend_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    TRFC
  } state_t;

  localparam logic [3:0] MAXP = 4'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] icnt;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W:0]   icnt_inc;
  logic             tick;
  logic             take;
  logic             done_q;
  logic             done_nxt;

  // One extra bit keeps interval 0 ticking every cycle
  assign icnt_inc = {1'b0, icnt} + (CNT_W+1)'(1);
  assign tick = aref_en &&
                (icnt_inc >= {1'b0, aref_interval});
  assign take = (state == REQ) && arb.ref_ack;

  assign arb.ref_req  = (state == REQ);
  assign arb.ref_busy = (state == TRFC);
  assign arb.ref_done = done_q;

  // Free-running interval counter, held clear when off
  always_ff @(posedge clk) begin
    if (rst || !aref_en) begin
      icnt <= '0;
    end else if (tick) begin
      icnt <= '0;
    end else begin
      icnt <= icnt_inc[CNT_W-1:0];
    end
  end

  // Owed refresh count with saturation and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
    end else if (!aref_en) begin
      pend_cnt <= '0;
    end else if (tick && !take) begin
      if (pend_cnt == MAXP) begin
        pend_ovf <= 1'b1;
      end else begin
        pend_cnt <= pend_cnt + 4'd1;
      end
    end else if (!tick && take && pend_cnt != 4'd0) begin
      pend_cnt <= pend_cnt - 4'd1;
    end
  end

  // Blackout length latched at ack, never shorter than 1
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (take) begin
      tcnt <= (trfc == '0) ? ONE : trfc;
    end else if (state == TRFC) begin
      tcnt <= tcnt - ONE;
    end
  end

  // State register and end-of-blackout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  // Next state; an ack always wins over disable
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (aref_en && pend_cnt != 4'd0) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (arb.ref_ack) begin
          state_nxt = TRFC;
        end else if (!aref_en) begin
          state_nxt = IDLE;
        end
      end
      TRFC: begin
        if (tcnt == ONE) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_autoref_scheduler.sv
// Scoreboard bench for autoref_scheduler: a cycle model
// pushes expectations, a monitor pops and compares.
module tb_autoref_scheduler;

  localparam int MAXP = 8;

  typedef struct packed {
    logic       req;
    logic       busy;
    logic       done;
    logic [3:0] pend;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        aref_en;
  logic [27:0] aref_interval;
  logic [27:0] trfc;
  logic [3:0]  pend_cnt;
  logic        pend_ovf;

  int errors = 0;
  int checks = 0;

  exp_t q[$];

  longint m_icnt = 0;
  int     m_owed = 0;
  int     m_busy = 0;
  bit     m_req  = 0;
  bit     m_done = 0;
  bit     m_ovf  = 0;

  autoref_scheduler_if arb_if ();

  autoref_scheduler #(
    .CNT_W    (28),
    .MAX_PEND (MAXP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .aref_en       (aref_en),
    .aref_interval (aref_interval),
    .trfc          (trfc),
    .arb           (arb_if),
    .pend_cnt      (pend_cnt),
    .pend_ovf      (pend_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_step(
    input bit r, input bit e,
    input longint iv, input longint tf,
    input bit a
  );
    bit tick;
    bit took;
    bit nreq;
    int nbusy;
    int nowed;
    if (r) begin
      m_icnt = 0; m_owed = 0; m_busy = 0;
      m_req = 0; m_done = 0; m_ovf = 0;
      return;
    end
    tick = e && (m_icnt + 1 >= iv);
    took = m_req && a;
    if (took) nreq = 0;
    else if (m_req) nreq = e;
    else if (m_busy == 0) nreq = e && (m_owed > 0);
    else nreq = 0;
    m_done = (m_busy == 1);
    if (took) nbusy = (tf == 0) ? 1 : int'(tf);
    else nbusy = (m_busy > 0) ? m_busy - 1 : 0;
    if (!e) begin
      nowed = 0;
    end else begin
      nowed = m_owed + int'(tick) - int'(took);
      if (nowed > MAXP) begin
        nowed = MAXP;
        m_ovf = 1;
      end
      if (nowed < 0) nowed = 0;
    end
    if (!e || tick) m_icnt = 0;
    else m_icnt = m_icnt + 1;
    m_req  = nreq;
    m_busy = nbusy;
    m_owed = nowed;
  endtask

  task automatic cyc(
    input bit r, input bit e,
    input int iv, input int tf,
    input bit a
  );
    exp_t x;
    rst = r;
    aref_en = e;
    aref_interval = 28'(iv);
    trfc = 28'(tf);
    arb_if.ref_ack = a;
    model_step(r, e, longint'(iv), longint'(tf), a);
    x.req  = m_req;
    x.busy = (m_busy > 0);
    x.done = m_done;
    x.pend = 4'(m_owed);
    x.ovf  = m_ovf;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(
    input string nm, input int got, input int want
  );
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic wait_req(
    input int iv, input int tf, input int bound,
    input string nm
  );
    int n = 0;
    while (arb_if.ref_req !== 1'b1 && n < bound) begin
      cyc(0, 1, iv, tf, 0);
      n++;
    end
    chk(nm, int'(arb_if.ref_req === 1'b1), 1);
  endtask

  // Monitor: compare every presented cycle with the queue
  always @(posedge clk) begin
    exp_t g;
    exp_t w;
    #1;
    if (q.size() != 0) begin
      w = q.pop_front();
      g = {arb_if.ref_req, arb_if.ref_busy,
           arb_if.ref_done, pend_cnt, pend_ovf};
      checks++;
      if (g !== w) begin
        errors++;
        $display(
          "FAIL cycle@%0t: got req%b busy%b done%b pend%0d ovf%b want req%b busy%b done%b pend%0d ovf%b",
          $time, g.req, g.busy, g.done, g.pend, g.ovf,
          w.req, w.busy, w.done, w.pend, w.ovf);
      end
      checks++;
      if ($countones({g.req, g.busy, g.done}) > 1) begin
        errors++;
        $display("FAIL exclusive: got %b want onehot0",
                 {g.req, g.busy, g.done});
      end
    end
  end

  initial begin
    rst = 1'b1;
    aref_en = 1'b0;
    aref_interval = '0;
    trfc = '0;
    arb_if.ref_ack = 1'b0;

    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("reset_pend", int'(pend_cnt), 0);

    // Basic refresh
    repeat (10) cyc(0, 1, 10, 5, m_req);
    chk("basic_pend_e9", int'(pend_cnt), 1);
    chk("basic_req_e9", int'(arb_if.ref_req), 0);
    cyc(0, 1, 10, 5, m_req);
    chk("basic_req_e10", int'(arb_if.ref_req), 1);
    repeat (40) cyc(0, 1, 10, 5, m_req);

    // Postpone and saturate
    cyc(1, 0, 3, 2, 0);
    repeat (40) cyc(0, 1, 3, 2, 0);
    chk("sat_pend", int'(pend_cnt), 8);
    chk("sat_ovf", int'(pend_ovf), 1);
    repeat (60) cyc(0, 1, 1000, 2, m_req);
    chk("drain_pend", int'(pend_cnt), 0);
    chk("drain_ovf", int'(pend_ovf), 1);

    // Tick coincident with ack at pend 2
    cyc(1, 0, 3, 4, 0);
    repeat (8) cyc(0, 1, 3, 4, 0);
    chk("coinc_pre", int'(pend_cnt), 2);
    cyc(0, 1, 3, 4, 1);
    chk("coinc_pend", int'(pend_cnt), 2);
    chk("coinc_busy", int'(arb_if.ref_busy), 1);
    repeat (10) cyc(0, 1, 3, 4, m_req);

    // Disable during REQ, then disable plus ack
    cyc(1, 0, 5, 6, 0);
    wait_req(5, 6, 20, "dis_wait1");
    repeat (2) cyc(0, 1, 5, 6, 0);
    cyc(0, 0, 5, 6, 0);
    chk("dis_req", int'(arb_if.ref_req), 0);
    chk("dis_pend", int'(pend_cnt), 0);
    repeat (3) cyc(0, 0, 5, 6, 0);
    wait_req(5, 6, 20, "dis_wait2");
    cyc(0, 0, 5, 6, 1);
    repeat (10) cyc(0, 0, 5, 6, 0);

    // Interval shrink, trfc 0, interval 1
    cyc(1, 0, 100, 0, 0);
    repeat (50) cyc(0, 1, 100, 0, 0);
    cyc(0, 1, 20, 0, 0);
    chk("shrink_tick", int'(pend_cnt), 1);
    repeat (60) cyc(0, 1, 20, 0, m_req);
    repeat (20) cyc(0, 1, 1, 0, 1'($urandom_range(0, 1)));

    // Reset at busy cycle 3 of 5
    cyc(1, 0, 4, 5, 0);
    for (int i = 0; i < 40 && m_busy != 3; i++) begin
      cyc(0, 1, 4, 5, m_req);
    end
    chk("rst_reach", int'(arb_if.ref_busy), 1);
    cyc(1, 1, 4, 5, 0);
    chk("rst_busy", int'(arb_if.ref_busy), 0);
    repeat (30) cyc(0, 1, 4, 5, m_req);

    // Randomized traffic
    begin
      int iv = 7;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) begin
          iv = $urandom_range(0, 12);
        end
        cyc(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 19) != 0),
            iv, $urandom_range(0, 6),
            1'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
